// File: rtl/alu_cc_pipe.sv
// -----------------------------------------------------------------------------
// alu_cc_pipe
//   Pipelined Y86 execute-stage ALU with registered condition codes.
//   Stage 1 computes ADD/SUB/AND/XOR plus ZF/SF/OF. Any later stages only
//   register the result. The pipe shifts as a whole whenever the output is
//   empty or being consumed. A retiring op with set_cc=1 loads its flags into
//   the architectural CC register.
//
//   Parameters
//     WIDTH   operand/result width (>= 2)
//     STAGES  latency in cycles from accept edge to out_valid (1..4)
//
//   Ports
//     clk, rst                 rising-edge clock, synchronous active-high reset
//     in_valid / in_ready      input handshake (in_ready = advance)
//     in_op                    00 ADD, 01 SUB, 10 AND, 11 XOR
//     in_a, in_b               operands
//     in_set_cc                commit this op's flags to CC when it retires
//     flush                    kill every in-flight op at the next edge
//     out_valid / out_ready    output handshake
//     out_result, out_zf/sf/of result and flags of the final-stage op
//     cc_zf/sf/of              architectural condition codes
//
//   Configuration macro: ALU_CC_BYPASS_EN
//     defined   : cc_* shows the retiring op's flags in the retire cycle
//                 (combinational path from out_ready).
//     undefined : cc_* is the CC register; updates are visible one cycle
//                 after the retire edge.
// -----------------------------------------------------------------------------
module alu_cc_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_of,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic             valid;
        logic             set_cc;
        logic             zf;
        logic             sf;
        logic             of;
        logic [WIDTH-1:0] result;
    } stage_t;

    stage_t     stage_q [STAGES];
    stage_t     stage_in;
    logic       advance;
    logic       retire;
    logic       commit;
    logic       cc_zf_q;
    logic       cc_sf_q;
    logic       cc_of_q;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic       sign_a;
    logic       sign_b;

    // The pipe only stalls when a valid result sits at the output unclaimed.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    assign sum    = in_a + in_b;
    assign diff   = in_a - in_b;
    assign sign_a = in_a[WIDTH-1];
    assign sign_b = in_b[WIDTH-1];

    // Stage-1 compute: result and flags for the op being presented.
    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch.
        stage_in        = '0;
        stage_in.valid  = in_valid;
        stage_in.set_cc = in_set_cc;
        unique case (alu_op_e'(in_op))
            OP_ADD: begin
                stage_in.result = sum;
                stage_in.of     = (sign_a == sign_b) && (sum[WIDTH-1] != sign_a);
            end
            OP_SUB: begin
                stage_in.result = diff;
                stage_in.of     = (sign_a != sign_b) && (diff[WIDTH-1] != sign_a);
            end
            OP_AND:  stage_in.result = in_a & in_b;
            OP_XOR:  stage_in.result = in_a ^ in_b;
            default: stage_in.result = '0;
        endcase
        stage_in.zf = (stage_in.result == '0);
        stage_in.sf = stage_in.result[WIDTH-1];
    end

    // Pipeline registers. Data shifts only on advance, so the output holds
    // steady during a stall. Flush clears every valid bit regardless of
    // advance; whatever was loaded into stage 1 this edge is discarded too.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data fields are reset as well, because out_result and the
            // output flags must read zero out of reset.
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            if (advance) begin
                // NOTE: non-blocking assignments make the shift read the
                // pre-edge value of each stage, whatever the loop order.
                stage_q[0] <= stage_in;
                for (int i = 1; i < STAGES; i++) begin
                    stage_q[i] <= stage_q[i-1];
                end
            end
            if (flush) begin
                for (int i = 0; i < STAGES; i++) begin
                    stage_q[i].valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = stage_q[STAGES-1].valid;
    assign out_result = stage_q[STAGES-1].result;
    assign out_zf     = stage_q[STAGES-1].zf;
    assign out_sf     = stage_q[STAGES-1].sf;
    assign out_of     = stage_q[STAGES-1].of;

    // A retiring transfer still commits when flush is asserted in the same
    // cycle; flush only affects what is left in the pipe.
    assign retire = out_valid && out_ready;
    assign commit = retire && stage_q[STAGES-1].set_cc;

    always_ff @(posedge clk) begin
        if (rst) begin
            cc_zf_q <= 1'b1;
            cc_sf_q <= 1'b0;
            cc_of_q <= 1'b0;
        end else if (commit) begin
            cc_zf_q <= out_zf;
            cc_sf_q <= out_sf;
            cc_of_q <= out_of;
        end
    end

`ifdef ALU_CC_BYPASS_EN
    // Forward the retiring op's flags so a consumer sees them in the same cycle.
    assign cc_zf = commit ? out_zf : cc_zf_q;
    assign cc_sf = commit ? out_sf : cc_sf_q;
    assign cc_of = commit ? out_of : cc_of_q;
`else
    assign cc_zf = cc_zf_q;
    assign cc_sf = cc_sf_q;
    assign cc_of = cc_of_q;
`endif

endmodule

// File: tb/tb_alu_cc_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_cc_pipe
//   Directed bench for alu_cc_pipe. Main instance: WIDTH=64, STAGES=2.
//   A second instance with STAGES=3 exercises flush with two ops in flight.
//   Inputs change 1 time unit after the rising edge; outputs are read there.
// -----------------------------------------------------------------------------
module tb_alu_cc_pipe;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_set_cc;
    logic         flush;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_result;
    logic         out_zf, out_sf, out_of;
    logic         cc_zf, cc_sf, cc_of;

    logic         d3_in_valid;
    logic         d3_in_ready;
    logic [1:0]   d3_in_op;
    logic [W-1:0] d3_in_a;
    logic [W-1:0] d3_in_b;
    logic         d3_in_set_cc;
    logic         d3_flush;
    logic         d3_out_valid;
    logic         d3_out_ready;
    logic [W-1:0] d3_out_result;
    logic         d3_out_zf, d3_out_sf, d3_out_of;
    logic         d3_cc_zf, d3_cc_sf, d3_cc_of;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_cc_pipe #(.WIDTH(W), .STAGES(2)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_set_cc  (in_set_cc),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zf     (out_zf),
        .out_sf     (out_sf),
        .out_of     (out_of),
        .cc_zf      (cc_zf),
        .cc_sf      (cc_sf),
        .cc_of      (cc_of)
    );

    alu_cc_pipe #(.WIDTH(W), .STAGES(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (d3_in_valid),
        .in_ready   (d3_in_ready),
        .in_op      (d3_in_op),
        .in_a       (d3_in_a),
        .in_b       (d3_in_b),
        .in_set_cc  (d3_in_set_cc),
        .flush      (d3_flush),
        .out_valid  (d3_out_valid),
        .out_ready  (d3_out_ready),
        .out_result (d3_out_result),
        .out_zf     (d3_out_zf),
        .out_sf     (d3_out_sf),
        .out_of     (d3_out_of),
        .cc_zf      (d3_cc_zf),
        .cc_sf      (d3_cc_sf),
        .cc_of      (d3_cc_of)
    );

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic set_cc);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_set_cc = set_cc;
    endtask

    task automatic check_cc(input string tag, input logic zf, input logic sf, input logic of_);
        check({tag, "_cc"}, {61'd0, cc_zf, cc_sf, cc_of}, {61'd0, zf, sf, of_});
    endtask

    initial begin
        int sent;
        int recv;
        logic [W-1:0] frozen;

        rst = 1'b1;
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        flush     = 1'b0;
        out_ready = 1'b1;
        d3_in_valid  = 1'b0;
        d3_in_op     = 2'b00;
        d3_in_a      = '0;
        d3_in_b      = '0;
        d3_in_set_cc = 1'b0;
        d3_flush     = 1'b0;
        d3_out_ready = 1'b1;
        frozen = '0;

        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_result", out_result, 64'd0);
        check("rst_out_flags", {61'd0, out_zf, out_sf, out_of}, 64'd0);
        check_cc("rst", 1'b1, 1'b0, 1'b0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // ---------------- ADD overflow ----------------
        drive(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        check("add_latency", {63'd0, out_valid}, 64'd0);
        tick();
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_result", out_result, 64'h8000_0000_0000_0000);
        check("add_flags", {61'd0, out_zf, out_sf, out_of}, {61'd0, 3'b011});
`ifdef ALU_CC_BYPASS_EN
        check_cc("add_retire_cycle", 1'b0, 1'b1, 1'b1);
`else
        check_cc("add_retire_cycle", 1'b1, 1'b0, 1'b0);
`endif
        tick();
        check_cc("add_after", 1'b0, 1'b1, 1'b1);
        check("add_drained", {63'd0, out_valid}, 64'd0);

        // ---------------- SUB then XOR back-to-back ----------------
        drive(1'b1, 2'b01, 64'd5, 64'd5, 1'b1);
        tick();
        drive(1'b1, 2'b11, 64'hF0, 64'h0F, 1'b0);
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        check("sub_valid", {63'd0, out_valid}, 64'd1);
        check("sub_result", out_result, 64'd0);
        check("sub_flags", {61'd0, out_zf, out_sf, out_of}, {61'd0, 3'b100});
        tick();
        check("xor_valid", {63'd0, out_valid}, 64'd1);
        check("xor_result", out_result, 64'hFF);
        check("xor_zf", {63'd0, out_zf}, 64'd0);
        check_cc("sub_retired", 1'b1, 1'b0, 1'b0);
        tick();
        check("xor_drained", {63'd0, out_valid}, 64'd0);
        check_cc("xor_retired", 1'b1, 1'b0, 1'b0);

        // ---------------- stream of 4 ADDs with a 3-cycle stall ----------------
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 4);
            drive(sent < 4, 2'b00, 64'h10, 64'(sent + 1), 1'b0);
            #1;
            if (!out_ready) begin
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                check("stall_out_valid", {63'd0, out_valid}, 64'd1);
                if (cyc == 2) frozen = out_result;
                else check("stall_frozen", out_result, frozen);
            end
            if (out_valid && out_ready) begin
                if (recv < 4) check("stream_result", out_result, 64'h11 + 64'(recv));
                else check("stream_dup", {63'd0, out_valid}, 64'd0);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        out_ready = 1'b1;
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        check("stream_frozen_value", frozen, 64'h11);
        check("stream_sent", 64'(sent), 64'd4);
        check("stream_recv", 64'(recv), 64'd4);

        // ---------------- flush with a retiring transfer ----------------
        drive(1'b1, 2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 2'b00, 64'd1, 64'd1, 1'b1);
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
        flush = 1'b0;
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
        check_cc("flush_commit", 1'b0, 1'b1, 1'b1);
        tick();
        check("flush_discard", {63'd0, out_valid}, 64'd0);
        check_cc("flush_hold", 1'b0, 1'b1, 1'b1);

        // ---------------- reset mid-operation ----------------
        drive(1'b1, 2'b00, 64'd1, 64'd2, 1'b1);
        tick();
        drive(1'b1, 2'b00, 64'd3, 64'd4, 1'b1);
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        check("midrst_pre_result", out_result, 64'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_out_result", out_result, 64'd0);
        check_cc("midrst", 1'b1, 1'b0, 1'b0);
        tick();
        check("midrst_pipe_empty", {63'd0, out_valid}, 64'd0);

        // ---------------- flush with STAGES=3 ----------------
        d3_in_valid  = 1'b1;
        d3_in_op     = 2'b00;
        d3_in_a      = 64'd1;
        d3_in_b      = 64'd1;
        d3_in_set_cc = 1'b1;
        tick();
        d3_in_a = 64'd2;
        d3_in_b = 64'd2;
        tick();
        d3_in_valid = 1'b0;
        d3_flush    = 1'b1;
        check("s3_not_yet", {63'd0, d3_out_valid}, 64'd0);
        tick();
        d3_flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("s3_flushed", {63'd0, d3_out_valid}, 64'd0);
            tick();
        end
        check("s3_cc", {61'd0, d3_cc_zf, d3_cc_sf, d3_cc_of}, {61'd0, 3'b100});

        // ---------------- CC visibility for AND 0 & x ----------------
        drive(1'b1, 2'b00, 64'd1, 64'd2, 1'b1);
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        tick();
        tick();
        check_cc("pre_and", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 64'd0, 64'hDEAD, 1'b1);
        tick();
        drive(1'b0, 2'b00, '0, '0, 1'b0);
        out_ready = 1'b0;
        tick();
        check("and_zf", {63'd0, out_zf}, 64'd1);
        check("and_stalled_cc_zf", {63'd0, cc_zf}, 64'd0);
        out_ready = 1'b1;
        #1;
`ifdef ALU_CC_BYPASS_EN
        check("and_retire_cc_zf", {63'd0, cc_zf}, 64'd1);
`else
        check("and_retire_cc_zf", {63'd0, cc_zf}, 64'd0);
`endif
        tick();
        check("and_after_cc_zf", {63'd0, cc_zf}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
